lcd_spi_writer: RTL



---
 rtl/lcd_spi_writer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/lcd_spi_writer.sv
// Byte-level 4-wire SPI transmitter for the ST7735 LCD.
// Takes one {D/C, byte} word per request, frames it with CS, shifts it out
// MSB-first in SPI mode 0, then pulses wr_done and enforces a CS-high gap
// before the next word can be sampled.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | CS high, waiting for en_write; the accepting edge is S
// SETUP | CS low, MOSI holds bit 7, SCLK low for one half-period
// SHIFT | SCLK toggling; MOSI advances on each falling toggle
// HOLD  | SCLK low after the 8th high phase, CS still low
// GAP   | CS high, en_write ignored, busy still asserted

module lcd_spi_writer #(
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       en_write,
  input  logic [8:0] data_in,
  output logic       wr_done,
  output logic       busy,
  output logic       lcd_sclk,
  output logic       lcd_mosi,
  output logic       lcd_cs_n,
  output logic       lcd_dc
);

  // One counter serves both the SCLK half-period and the gap, so it is
  // sized for whichever of the two is longer.
  localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t        state_q;
  logic [CW-1:0] div_cnt_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          sclk_q;
  logic          mosi_q;
  logic          cs_n_q;
  logic          dc_q;
  logic          done_q;
  logic          busy_q;

  logic          div_tc;
  logic          gap_tc;

  // Terminal-count compares for the half-period and gap timers.
  assign div_tc = (div_cnt_q == DIV_LAST);
  assign gap_tc = (div_cnt_q == GAP_LAST);

  // Transfer sequencer; every pin is driven straight from a flop.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      dc_q      <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en_write) begin
            shift_q   <= data_in[7:0];
            dc_q      <= data_in[8];
            cs_n_q    <= 1'b0;
            mosi_q    <= data_in[7];
            busy_q    <= 1'b1;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            state_q   <= SETUP;
          end
        end

        SETUP: begin
          if (div_tc) begin
            div_cnt_q <= '0;
            sclk_q    <= 1'b1;
            state_q   <= SHIFT;
          end else begin
            div_cnt_q <= div_cnt_q + CNT_ONE;
          end
        end

        SHIFT: begin
          if (div_tc) begin
            div_cnt_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (bit_cnt_q == 3'd7) begin
                // End of the 8th high phase: no further bit to present.
                state_q <= HOLD;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                shift_q   <= {shift_q[6:0], 1'b0};
                mosi_q    <= shift_q[6];
              end
            end
          end else begin
            div_cnt_q <= div_cnt_q + CNT_ONE;
          end
        end

        HOLD: begin
          if (div_tc) begin
            div_cnt_q <= '0;
            cs_n_q    <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= GAP;
          end else begin
            div_cnt_q <= div_cnt_q + CNT_ONE;
          end
        end

        GAP: begin
          // The gap lets the upstream advance its pointer and re-register
          // data_in / en_write before the next possible sample.
          if (gap_tc) begin
            div_cnt_q <= '0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            div_cnt_q <= div_cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign wr_done  = done_q;
  assign busy     = busy_q;
  assign lcd_sclk = sclk_q;
  assign lcd_mosi = mosi_q;
  assign lcd_cs_n = cs_n_q;
  assign lcd_dc   = dc_q;

endmodule
